// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_sched clock-enable scheduler.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int unsigned DIV_MIN    = 2;
  localparam int unsigned TICK_CNT_W = 16;

endpackage

// File: rtl/clk_div_sched_if.sv
// Ratio configuration handshake between the control register block and clk_div_sched.
interface clk_div_sched_if #(
  parameter int unsigned CNT_W = 8
);

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_period_cnt.sv
// Period counter for clk_div_sched: counts 0..last_i, exposes its next value and the wrap cycle.
module clk_div_period_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] last_i,
  output logic [CNT_W-1:0] cnt_nxt_c_o,
  output logic             wrap_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    wrap_c_o = run_i && (cnt_q == last_i);
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = wrap_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign cnt_nxt_c_o = cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Programmable tick/phase enable scheduler; ratio changes land only on period boundaries.
// Optional CLKDIV_TICK_CNT_EN adds a free-running 16-bit tick counter output.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  clk_div_sched_if.slave        cfg,
  output logic                  tick,
  output logic                  phase,
  output logic                  busy
`ifdef CLKDIV_TICK_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;

  logic             accept;
  logic             legal;
  logic             cnt_clr;
  logic             cnt_run;
  logic             wrap;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_clr = (state_q == IDLE);
  assign cnt_run = !cnt_clr;

  clk_div_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .run_i       (cnt_run),
    .last_i      (div_q - CNT_W'(1)),
    .cnt_nxt_c_o (cnt_nxt),
    .wrap_c_o    (wrap)
  );

  // Next-state: handshake, pending ratio and FSM.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    busy_d     = 1'b0;

    accept    = cfg.cfg_valid && !pend_vld_q;
    legal     = (cfg.cfg_div >= CNT_W'(DIV_MIN));
    cfg_err_d = accept && !legal;

    unique case (state_q)
      IDLE: begin
        if (accept && legal) div_d = cfg.cfg_div;
        if (enable && (div_d >= CNT_W'(DIV_MIN))) state_d = RUN;
      end
      RUN, STOP: begin
        if (accept && legal) begin
          pend_d     = cfg.cfg_div;
          pend_vld_d = 1'b1;
        end
        if (wrap) begin
          if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
          end
          // A stop requested in the boundary cycle itself ends here.
          if ((state_q == STOP) || !enable) state_d = IDLE;
        end else if ((state_q == RUN) && !enable) begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Outputs are computed from next-state values so the flops line up with cnt_q.
  always_comb begin
    tick_d  = busy_d && (cnt_nxt == (div_d - CNT_W'(1)));
    phase_d = busy_d && (cnt_nxt >= (div_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick          = tick_q;
  assign phase         = phase_q;
  assign busy          = busy_q;
  assign cfg.cfg_ready = !pend_vld_q;
  assign cfg.cfg_err   = cfg_err_q;

`ifdef CLKDIV_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_CNT_W'(tick_q);
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed self-checking bench for clk_div_sched.
module tb_clk_div_sched;

  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic tick;
  logic phase;
  logic busy;
`ifdef CLKDIV_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  clk_div_sched_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_sched #(
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .cfg      (cfg_if.slave),
    .tick     (tick),
    .phase    (phase),
    .busy     (busy)
`ifdef CLKDIV_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [CNT_W-1:0] n);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = n;
  endtask

  logic [11:0] exp_tick12, exp_phase12;
  logic [9:0]  exp_tick10, exp_phase10;
  logic [5:0]  exp_tick6,  exp_phase6;

  initial begin
    rst              = 1'b1;
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    step(2);
    rst = 1'b0;
    chk("rst_tick",  32'(tick), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_err",   32'(cfg_if.cfg_err), 32'd0);

    // Basic run at N=4, accept and enable in the same cycle.
    offer(8'd4);
    enable = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("n4_busy", 32'(busy), 32'd1);
    exp_tick12  = 12'b1000_1000_1000;
    exp_phase12 = 12'b1100_1100_1100;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("n4_tick_c%0d", k),  32'(tick),  32'(exp_tick12[k]));
      chk($sformatf("n4_phase_c%0d", k), 32'(phase), 32'(exp_phase12[k]));
      step();
    end
    enable = 1'b0;
    step(3);
    chk("n4_stop_tick", 32'(tick), 32'd1);
    chk("n4_stop_busy", 32'(busy), 32'd1);
    step();
    chk("n4_idle_busy",  32'(busy), 32'd0);
    chk("n4_idle_tick",  32'(tick), 32'd0);
    chk("n4_idle_phase", 32'(phase), 32'd0);

    // Odd ratio N=5.
    offer(8'd5);
    step();
    cfg_if.cfg_valid = 1'b0;
    enable = 1'b1;
    step();
    exp_tick10  = 10'b10000_10000;
    exp_phase10 = 10'b11100_11100;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("n5_tick_c%0d", k),  32'(tick),  32'(exp_tick10[k]));
      chk($sformatf("n5_phase_c%0d", k), 32'(phase), 32'(exp_phase10[k]));
      step();
    end
    enable = 1'b0;
    step(5);
    chk("n5_idle_busy", 32'(busy), 32'd0);

    // Mid-run switch 4 -> 6 with a second offer held off.
    offer(8'd4);
    enable = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    offer(8'd6);
    step();
    chk("sw_ready_c2", 32'(cfg_if.cfg_ready), 32'd0);
    offer(8'd9);
    step();
    chk("sw_ready_c3", 32'(cfg_if.cfg_ready), 32'd0);
    chk("sw_tick_c3",  32'(tick), 32'd1);
    cfg_if.cfg_valid = 1'b0;
    step();
    chk("sw_ready_c4", 32'(cfg_if.cfg_ready), 32'd1);
    chk("sw_div_c4",   32'(dut.div_q), 32'd6);
    exp_tick12  = 12'b1000_0010_0000;
    exp_phase12 = 12'b1110_0011_1000;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("n6_tick_c%0d", k + 4),  32'(tick),  32'(exp_tick12[k]));
      chk($sformatf("n6_phase_c%0d", k + 4), 32'(phase), 32'(exp_phase12[k]));
      step();
    end
    enable = 1'b0;
    step(6);
    chk("n6_idle_busy", 32'(busy), 32'd0);

    // Illegal ratio while running at N=3.
    offer(8'd3);
    enable = 1'b1;
    step();
    offer(8'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("ill_err_c1",   32'(cfg_if.cfg_err), 32'd1);
    chk("ill_ready_c1", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    chk("ill_err_c2", 32'(cfg_if.cfg_err), 32'd0);
    exp_tick6 = 6'b001001;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ill_tick_c%0d", k + 2),  32'(tick), 32'(exp_tick6[k]));
      chk($sformatf("ill_ready_c%0d", k + 2), 32'(cfg_if.cfg_ready), 32'd1);
      step();
    end
    chk("ill_div", 32'(dut.div_q), 32'd3);
    step();
    enable = 1'b0;
    step(3);
    chk("ill_idle_busy", 32'(busy), 32'd0);

    // Stop at N=8 with a simultaneous N=3 offer.
    offer(8'd8);
    enable = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step(2);
    enable = 1'b0;
    offer(8'd3);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("stp_busy_c3",  32'(busy), 32'd1);
    chk("stp_ready_c3", 32'(cfg_if.cfg_ready), 32'd0);
    step(4);
    chk("stp_tick_c7", 32'(tick), 32'd1);
    step();
    chk("stp_busy_c8",  32'(busy), 32'd0);
    chk("stp_tick_c8",  32'(tick), 32'd0);
    chk("stp_div_c8",   32'(dut.div_q), 32'd3);
    chk("stp_ready_c8", 32'(cfg_if.cfg_ready), 32'd1);
    enable = 1'b1;
    step();
    exp_tick6  = 6'b100100;
    exp_phase6 = 6'b110110;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("re3_tick_c%0d", k),  32'(tick),  32'(exp_tick6[k]));
      chk($sformatf("re3_phase_c%0d", k), 32'(phase), 32'(exp_phase6[k]));
      step();
    end

    // Reset at cycle 2 of an N=4 period.
    offer(8'd4);
    step();
    cfg_if.cfg_valid = 1'b0;
    step(4);
    chk("rm_phase_c2", 32'(phase), 32'd1);
    chk("rm_busy_c2",  32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_tick",  32'(tick), 32'd0);
    chk("rm_phase", 32'(phase), 32'd0);
    chk("rm_busy",  32'(busy), 32'd0);
    chk("rm_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rm_err",   32'(cfg_if.cfg_err), 32'd0);
    chk("rm_div",   32'(dut.div_q), 32'd0);
`ifdef CLKDIV_TICK_CNT_EN
    chk("rm_tick_cnt", 32'(tick_cnt), 32'd0);
`endif
    step();
    chk("rm_tick_after", 32'(tick), 32'd0);
    chk("rm_busy_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
